// File: rtl/loop_restore.sv
// Row-layer write-back: rebuilds the check-to-variable message and restores the saturated posterior.
// Define OFFSET_MS_EN to subtract OFFSET from the selected magnitude (offset min-sum).
module loop_restore #(
    parameter int W      = 8,
    parameter int DEG    = 32,
    parameter int IDX_W  = 5,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-2:0]     min1,
    input  logic [W-2:0]     min2,
    input  logic [IDX_W-1:0] min_idx,
    input  logic             sign_prod,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ext_sign,
    input  logic [W-1:0]     ext_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     q_out,
    output logic [W-1:0]     r_out,
    output logic [IDX_W-1:0] col_idx,
    output logic             busy,
    output logic             row_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

`ifdef OFFSET_MS_EN
    localparam bit OFS_EN = 1'b1;
`else
    localparam bit OFS_EN = 1'b0;
`endif

    localparam logic [IDX_W-1:0]    LAST_COL = IDX_W'(DEG - 1);
    localparam logic [W-2:0]        OFS      = (W-1)'(OFFSET);
    localparam logic signed [W+1:0] Q_MAX    = (W+2)'((2 ** (W - 1)) - 1);

    // Clamp to the symmetric range so the most negative code never reaches q memory.
    function automatic logic [W-1:0] sat_sym(input logic signed [W+1:0] v);
        logic signed [W+1:0] lim;
        lim = Q_MAX;
        if (v > lim) begin
            sat_sym = lim[W-1:0];
        end else if (v < -lim) begin
            lim     = -lim;
            sat_sym = lim[W-1:0];
        end else begin
            sat_sym = v[W-1:0];
        end
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] cnt_r;
    logic [W-2:0]     min1_r;
    logic [W-2:0]     min2_r;
    logic [IDX_W-1:0] min_idx_r;
    logic             sign_prod_r;
    logic             out_valid_r;
    logic [W-1:0]     q_r;
    logic [W-1:0]     r_r;
    logic [IDX_W-1:0] col_r;
    logic             row_done_r;

    logic             accept_s;
    logic [W-2:0]     mag_raw_s;
    logic [W-2:0]     mag_s;
    logic [W-1:0]     mag_ext_s;
    logic [W-1:0]     r_new_s;
    logic [W:0]       ext_full_s;
    logic [W:0]       ext_s;
    logic signed [W+1:0] sum_s;

    assign in_ready  = (state_r == ST_RUN) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign mag_raw_s = (cnt_r == min_idx_r) ? min2_r : min1_r;

    // Optional offset reduction of the selected magnitude, floored at zero.
    always_comb begin
        mag_s = mag_raw_s;
        if (OFS_EN && (mag_raw_s > OFS)) begin
            mag_s = mag_raw_s - OFS;
        end else if (OFS_EN) begin
            mag_s = {(W-1){1'b0}};
        end else begin
            mag_s = mag_raw_s;
        end
    end

    assign mag_ext_s  = {1'b0, mag_s};
    assign r_new_s    = (sign_prod_r ^ ext_sign) ? -mag_ext_s : mag_ext_s;
    assign ext_full_s = {1'b0, ext_mag};
    assign ext_s      = ext_sign ? -ext_full_s : ext_full_s;
    assign sum_s      = {ext_s[W], ext_s} + {{2{r_new_s[W-1]}}, r_new_s};

    assign out_valid = out_valid_r;
    assign q_out     = q_r;
    assign r_out     = r_r;
    assign col_idx   = col_r;
    assign row_done  = row_done_r;
    assign busy      = (state_r != ST_IDLE);

    // Row control FSM together with the one-deep output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {IDX_W{1'b0}};
            min1_r      <= {(W-1){1'b0}};
            min2_r      <= {(W-1){1'b0}};
            min_idx_r   <= {IDX_W{1'b0}};
            sign_prod_r <= 1'b0;
            out_valid_r <= 1'b0;
            q_r         <= {W{1'b0}};
            r_r         <= {W{1'b0}};
            col_r       <= {IDX_W{1'b0}};
            row_done_r  <= 1'b0;
        end else begin
            row_done_r <= 1'b0;
            if (accept_s) begin
                out_valid_r <= 1'b1;
                q_r         <= sat_sym(sum_s);
                r_r         <= r_new_s;
                col_r       <= cnt_r;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        min1_r      <= min1;
                        min2_r      <= min2;
                        min_idx_r   <= min_idx;
                        sign_prod_r <= sign_prod;
                        cnt_r       <= {IDX_W{1'b0}};
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_COL) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_r && out_ready) begin
                        row_done_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_restore.sv
// Randomized scoreboard bench for loop_restore (W=8, DEG=4) with a behavioural reference model.
module tb_loop_restore;
    localparam int W     = 8;
    localparam int DEG   = 4;
    localparam int IDX_W = 3;
    localparam int OFS   = 1;
    localparam int QMAX  = (2 ** (W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-2:0]     min1 = '0;
    logic [W-2:0]     min2 = '0;
    logic [IDX_W-1:0] min_idx = '0;
    logic             sign_prod = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ext_sign = 1'b0;
    logic [W-1:0]     ext_mag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     q_out;
    logic [W-1:0]     r_out;
    logic [IDX_W-1:0] col_idx;
    logic             busy;
    logic             row_done;

    loop_restore #(.W(W), .DEG(DEG), .IDX_W(IDX_W), .OFFSET(OFS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .min1(min1), .min2(min2),
        .min_idx(min_idx), .sign_prod(sign_prod), .in_valid(in_valid),
        .in_ready(in_ready), .ext_sign(ext_sign), .ext_mag(ext_mag),
        .out_valid(out_valid), .out_ready(out_ready), .q_out(q_out), .r_out(r_out),
        .col_idx(col_idx), .busy(busy), .row_done(row_done)
    );

    always #5 clk = ~clk;

    typedef struct { int q; int r; int col; bit last; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ready_mode = 0;
    int   bes[DEG];
    int   bem[DEG];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: select magnitude, restore signs, add, clamp.
    function automatic void model(input int m1, input int m2, input int idx, input int sp,
                                  input int es, input int em, input int c,
                                  output int q, output int r);
        int mag;
        int e;
        mag = (c == idx) ? m2 : m1;
`ifdef OFFSET_MS_EN
        mag = (mag > OFS) ? mag - OFS : 0;
`endif
        r = ((sp ^ es) != 0) ? -mag : mag;
        e = (es != 0) ? -em : em;
        q = e + r;
        if (q > QMAX) q = QMAX;
        if (q < -QMAX) q = -QMAX;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each output handshake.
    bit               done_exp = 1'b0;
    bit               hold = 1'b0;
    logic [W-1:0]     pq;
    logic [W-1:0]     pr;
    logic [IDX_W-1:0] pc;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done_exp = 1'b0;
            hold = 1'b0;
        end else begin
            check(row_done == done_exp, "row_done", int'(row_done), int'(done_exp));
            if (done_exp) check(busy == 1'b0, "busy_after_row", int'(busy), 0);
            done_exp = 1'b0;
            if (hold) check(out_valid && q_out == pq && r_out == pr && col_idx == pc,
                            "hold_stable", int'(q_out), int'(pq));
            hold = 1'b0;
            if (out_valid && !out_ready) begin
                check(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
                hold = 1'b1;
                pq = q_out; pr = r_out; pc = col_idx;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_out", int'(col_idx), -1);
                end else begin
                    e = sb.pop_front();
                    check(int'($signed(q_out)) == e.q, "q_out", int'($signed(q_out)), e.q);
                    check(int'($signed(r_out)) == e.r, "r_out", int'($signed(r_out)), e.r);
                    check(int'(col_idx) == e.col, "col_idx", int'(col_idx), e.col);
                    done_exp = e.last;
                end
            end
        end
    end

    task automatic do_row(input int m1, input int m2, input int idx, input int sp,
                          input int abort_at, input bit mid_start, input int bp_at,
                          input bit gaps);
        exp_t e;
        bit   got;
        int   q;
        int   r;
        @(posedge clk); #1;
        start = 1'b1; min1 = (W-1)'(m1); min2 = (W-1)'(m2);
        min_idx = IDX_W'(idx); sign_prod = 1'(sp);
        in_valid = 1'b1; ext_sign = 1'(bes[0]); ext_mag = W'(bem[0]);
        @(negedge clk);
        check(in_ready == 1'b0, "idle_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        min1 = (W-1)'($urandom); min2 = (W-1)'($urandom);
        min_idx = IDX_W'($urandom); sign_prod = 1'($urandom);
        for (int c = 0; c < DEG; c++) begin
            if (c == abort_at) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check(out_valid == 1'b0, "abort_out_valid", int'(out_valid), 0);
                check(busy == 1'b0, "abort_busy", int'(busy), 0);
                check(row_done == 1'b0, "abort_row_done", int'(row_done), 0);
                sb.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (gaps && c > 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (mid_start && c == 2) begin
                start = 1'b1; min1 = (W-1)'(m1 ^ 5); min2 = (W-1)'(m2 ^ 9);
                min_idx = IDX_W'(idx + 1); sign_prod = 1'(~sp);
            end
            if (c == bp_at) begin
                ready_mode = 2;
                fork
                    begin repeat (3) @(posedge clk); ready_mode = 0; end
                join_none
            end
            in_valid = 1'b1; ext_sign = 1'(bes[c]); ext_mag = W'(bem[c]);
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    model(m1, m2, idx, sp, bes[c], bem[c], c, q, r);
                    e.q = q; e.r = r; e.col = c; e.last = (c == DEG - 1);
                    sb.push_back(e);
                    got = 1'b1;
                end
            end
            if (!got) check(1'b0, "beat_timeout", c, -1);
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) got = 1'b1;
        end
        if (!got) check(1'b0, "drain_timeout", sb.size(), 0);
    endtask

    task automatic set_beats(input int s0, input int m0, input int s1, input int m1v,
                             input int s2, input int m2v, input int s3, input int m3v);
        bes[0] = s0; bem[0] = m0; bes[1] = s1; bem[1] = m1v;
        bes[2] = s2; bem[2] = m2v; bes[3] = s3; bem[3] = m3v;
    endtask

    initial begin
        #3;
        check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        check(q_out == '0, "rst_q_out", int'(q_out), 0);
        check(r_out == '0, "rst_r_out", int'(r_out), 0);
        check(col_idx == '0, "rst_col_idx", int'(col_idx), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(row_done == 1'b0, "rst_row_done", int'(row_done), 0);
        check(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        set_beats(0, 10, 1, 5, 0, 20, 0, 1);
        do_row(3, 7, 2, 0, -1, 1'b0, -1, 1'b0);
        set_beats(0, 120, 1, 120, 1, 255, 1, 0);
        do_row(100, 100, 7, 0, -1, 1'b0, -1, 1'b0);
        do_row(100, 90, 5, 1, -1, 1'b0, -1, 1'b0);
        set_beats(0, 10, 1, 5, 0, 20, 0, 1);
        do_row(3, 7, 1, 0, -1, 1'b0, 2, 1'b0);
        do_row(4, 9, 3, 1, -1, 1'b1, -1, 1'b0);
        do_row(3, 7, 2, 0, 2, 1'b0, -1, 1'b0);
        do_row(3, 7, 0, 1, -1, 1'b0, -1, 1'b0);
        set_beats(0, 17, 1, 33, 0, 0, 1, 2);
        do_row(0, 1, 1, 0, -1, 1'b0, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int c = 0; c < DEG; c++) begin
                bes[c] = int'($urandom_range(0, 1));
                bem[c] = int'($urandom_range(0, 255));
            end
            ready_mode = (n % 3 == 0) ? 0 : 1;
            do_row(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   -1, 1'b0, -1, 1'b1);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
